// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_checker
// Brief    : Applies the four 2-input vectors to a gate under test, samples
//            its output after a settle time and checks it against EXP.
// Revision : 1.0 - initial release
// ============================================================================
module gate_tt_checker #(
    parameter logic [3:0]  EXP    = 4'b1110,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z_in,
    output logic       x_out,
    output logic       y_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] C_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic [2:0] r_err_cnt;
    logic [3:0] r_fail_mask;
    logic       w_mismatch;

    assign w_mismatch = (z_in != EXP[r_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 4'd0;
            r_err_cnt   <= 3'd0;
            r_fail_mask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_DRIVE;
                        r_idx       <= 2'd0;
                        r_cnt       <= C_RELOAD;
                        r_err_cnt   <= 3'd0;
                        r_fail_mask <= 4'd0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == 4'd0) begin
                        if (w_mismatch) begin
                            r_err_cnt          <= r_err_cnt + 3'd1;
                            r_fail_mask[r_idx] <= 1'b1;
                        end
                        if (r_idx == 2'd3) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            r_cnt <= C_RELOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Vector lines idle at 00 outside DRIVE so the gate sees a quiet input.
    assign busy           = (r_state == S_DRIVE);
    assign done           = (r_state == S_DONE);
    assign {x_out, y_out} = busy ? r_idx : 2'b00;
    assign err_cnt        = r_err_cnt;
    assign fail_mask      = r_fail_mask;
    assign pass           = done && (r_err_cnt == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_tt_checker
// Brief    : Self-checking bench for gate_tt_checker (OR default and AND/S=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;

    localparam logic [3:0] EXP0 = 4'b1110;
    localparam logic [3:0] EXP1 = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, z0, x0, y0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] mask0;
    logic [3:0] tt0;

    logic       rst1, start1, z1, x1, y1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic [3:0] tt1;

    int tests = 0;
    int fails = 0;

    // Gate models: truth table looked up by {x,y}.
    assign z0 = tt0[{x0, y0}];
    assign z1 = tt1[{x1, y1}];

    gate_tt_checker dut0 (
        .clk(clk), .rst(rst0), .start(start0), .z_in(z0),
        .x_out(x0), .y_out(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_mask(mask0)
    );

    gate_tt_checker #(.EXP(EXP1), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .z_in(z1),
        .x_out(x1), .y_out(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_mask(mask1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n;
    endfunction

    // Starting at the negedge of cycle 0, run one S=2 check on dut0 and
    // verify the vector schedule and the final verdict at cycle 9.
    task automatic run0(input logic [3:0] tt, input bit mid_start);
        logic [3:0] exp_mask;
        int         exp_err;
        tt0      = tt;
        exp_mask = tt ^ EXP0;
        exp_err  = ones(exp_mask);
        start0   = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            check("run0_vec", {12'd0, busy0, done0, x0, y0},
                  {12'd0, 1'b1, 1'b0, 2'((t - 1) / 2)});
            if (t == 1) start0 = 1'b0;
            if (mid_start && t == 4) start0 = 1'b1;
            if (mid_start && t == 5) start0 = 1'b0;
        end
        @(negedge clk);
        check("run0_done", {12'd0, busy0, done0, x0, y0}, 16'b0100);
        check("run0_err", {13'd0, err0}, 16'(exp_err));
        check("run0_mask", {12'd0, mask0}, {12'd0, exp_mask});
        check("run0_pass", {15'd0, pass0}, {15'd0, exp_err == 0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_mask;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tt0 = EXP0; tt1 = EXP1;
        repeat (2) @(negedge clk);
        check("reset0", {3'd0, x0, y0, busy0, done0, pass0, err0, mask0}, 16'd0);
        check("reset1", {3'd0, x1, y1, busy1, done1, pass1, err1, mask1}, 16'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        run0(4'b1110, 1'b0);    // clean OR
        run0(4'b0000, 1'b0);    // stuck at 0
        run0(4'b1111, 1'b0);    // stuck at 1
        run0(4'b1110, 1'b1);    // mid-run start ignored

        // Mid-run reset with an error already recorded, then restart at cycle 8.
        tt0 = 4'b0000;
        start0 = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (t == 1) start0 = 1'b0;
        end
        check("pre_rst_err", {13'd0, err0}, 16'd1);
        rst0 = 1'b1;
        @(negedge clk);
        check("post_rst", {3'd0, x0, y0, busy0, done0, pass0, err0, mask0}, 16'd0);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);
        run0(4'b1110, 1'b0);

        // Random gate behaviour; expectations from the XOR against EXP.
        for (int i = 0; i < 6; i++) run0(4'($urandom), 1'b0);

        // dut1: AND, S=1, start held high -> back-to-back 5-cycle runs.
        tt1 = EXP1;
        start1 = 1'b1;
        for (int r = 0; r < 5; r++) begin
            exp_mask = tt1 ^ EXP1;
            for (int t = 1; t <= 4; t++) begin
                @(negedge clk);
                check("run1_vec", {12'd0, busy1, done1, x1, y1},
                      {12'd0, 1'b1, 1'b0, 2'(t - 1)});
            end
            @(negedge clk);
            check("run1_done", {12'd0, busy1, done1, x1, y1}, 16'b0100);
            check("run1_err", {13'd0, err1}, 16'(ones(exp_mask)));
            check("run1_mask", {12'd0, mask1}, {12'd0, exp_mask});
            check("run1_pass", {15'd0, pass1}, {15'd0, exp_mask == 4'd0});
            tt1 = (r == 0) ? 4'b1000 : 4'($urandom);
            if (r == 4) start1 = 1'b0;
        end
        exp_mask = mask1;
        repeat (2) begin
            @(negedge clk);
            check("run1_hold", {12'd0, busy1, done1, x1, y1}, 16'b0100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
